// File: rtl/holo_weight_bank_if.sv
// rtl/holo_weight_bank_if.sv - Port B chunk bus and Port A request/stream bundle for holo_weight_bank
interface holo_weight_bank_if #(
    parameter int CHUNK_BITS = 512,
    parameter int ACC_WIDTH  = 7,
    parameter int LAYER_W    = 9
);
    logic                            init_done;
    logic [31:0]                     weight_addr;
    logic                            weight_we;
    logic [CHUNK_BITS-1:0]           weight_wdata;
    logic [CHUNK_BITS-1:0]           weight_rdata;
    logic [31:0]                     accum_addr;
    logic                            accum_we;
    logic [CHUNK_BITS*ACC_WIDTH-1:0] accum_wdata;
    logic [CHUNK_BITS*ACC_WIDTH-1:0] accum_rdata;
    logic                            b_oob;
    logic                            a_req_valid;
    logic                            a_req_ready;
    logic [LAYER_W-1:0]              a_layer;
    logic                            a_err;
    logic                            a_tvalid;
    logic                            a_tready;
    logic [CHUNK_BITS-1:0]           a_tdata;
    logic                            a_tlast;
    logic                            a_tuser;

    modport slave (
        output init_done,
        input  weight_addr, weight_we, weight_wdata,
        output weight_rdata,
        input  accum_addr, accum_we, accum_wdata,
        output accum_rdata, b_oob,
        input  a_req_valid,
        output a_req_ready,
        input  a_layer,
        output a_err, a_tvalid,
        input  a_tready,
        output a_tdata, a_tlast, a_tuser
    );

    modport master (
        input  init_done,
        output weight_addr, weight_we, weight_wdata,
        input  weight_rdata,
        output accum_addr, accum_we, accum_wdata,
        input  accum_rdata, b_oob,
        output a_req_valid,
        input  a_req_ready,
        output a_layer,
        input  a_err, a_tvalid,
        output a_tready,
        input  a_tdata, a_tlast, a_tuser
    );
endinterface

// File: rtl/holo_weight_bank.sv
// rtl/holo_weight_bank.sv - weight/accumulator bank with chunk Port B and row-streaming Port A
module holo_weight_bank #(
    parameter int DIM        = 16384,
    parameter int N_LAYERS   = 512,
    parameter int CHUNK_BITS = 512,
    parameter int ACC_WIDTH  = 7,
    parameter int LAYER_W    = $clog2(N_LAYERS)
) (
    input logic               clk,
    input logic               rst_n,
    holo_weight_bank_if.slave bus
);
    localparam int NUM_CHUNKS = DIM / CHUNK_BITS;
    localparam int DEPTH      = N_LAYERS * NUM_CHUNKS;
    localparam int CW         = $clog2(NUM_CHUNKS);
    localparam int LW         = $clog2(N_LAYERS);
    localparam int AW         = $clog2(DEPTH);
    localparam int ADW        = CHUNK_BITS * ACC_WIDTH;
    localparam logic [31:0]   DEPTH32   = 32'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {A_IDLE, A_STREAM} a_state_t;

    logic [CHUNK_BITS-1:0] weight_mem [DEPTH];
    logic [ADW-1:0]        accum_mem  [DEPTH];

    logic          init_armed, init_done;
    logic [AW-1:0] init_cnt;
    logic          init_we;

    // One idle cycle after reset release, then one zero-write per clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_armed <= 1'b0;
            init_done  <= 1'b0;
            init_cnt   <= '0;
        end else if (!init_armed) begin
            init_armed <= 1'b1;
        end else if (!init_done) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST_ADDR) init_done <= 1'b1;
        end
    end

    assign init_we = rst_n && init_armed && !init_done;

    logic          bw_in, ba_in, bw_wr, ba_wr;
    logic [AW-1:0] bw_idx, ba_idx;
    logic [LW-1:0] bw_layer, ba_layer;

    assign bw_in    = bus.weight_addr < DEPTH32;
    assign ba_in    = bus.accum_addr < DEPTH32;
    assign bw_idx   = bus.weight_addr[AW-1:0];
    assign ba_idx   = bus.accum_addr[AW-1:0];
    assign bw_layer = bw_idx[AW-1:CW];
    assign ba_layer = ba_idx[AW-1:CW];
    assign bw_wr    = rst_n && init_done && bus.weight_we && bw_in;
    assign ba_wr    = rst_n && init_done && bus.accum_we && ba_in;

    always_ff @(posedge clk) begin
        if (init_we) begin
            weight_mem[init_cnt] <= '0;
            accum_mem[init_cnt]  <= '0;
        end else begin
            if (bw_wr) weight_mem[bw_idx] <= bus.weight_wdata;
            if (ba_wr) accum_mem[ba_idx]  <= bus.accum_wdata;
        end
    end

    logic [CHUNK_BITS-1:0] weight_rdata;
    logic [ADW-1:0]        accum_rdata;
    logic                  b_oob;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight_rdata <= '0;
            accum_rdata  <= '0;
            b_oob        <= 1'b0;
        end else begin
            weight_rdata <= (init_done && bw_in) ? weight_mem[bw_idx] : '0;
            accum_rdata  <= (init_done && ba_in) ? accum_mem[ba_idx] : '0;
            if (!bw_in || !ba_in) b_oob <= 1'b1;
        end
    end

    a_state_t              state;
    logic [LW-1:0]         layer_q;
    logic [CW:0]           rd_idx;
    logic                  stale, a_err;
    logic [1:0]            cnt;
    logic [CHUNK_BITS-1:0] q0, q1;
    logic                  q0_last, q1_last;
    logic                  req_ready, req_fire, layer_ok, pop, issue, push_last;
    logic                  hit_new, hit_cur;
    logic [LW-1:0]         new_layer;
    logic [AW-1:0]         rd_addr;

    assign req_ready = (state == A_IDLE) && init_done;
    assign req_fire  = bus.a_req_valid && req_ready;
    assign layer_ok  = 32'(bus.a_layer) < 32'(N_LAYERS);
    assign new_layer = bus.a_layer[LW-1:0];
    assign pop       = (cnt != 2'd0) && bus.a_tready;
    // Issue only if the two-entry buffer has room once this cycle's pop is counted.
    assign issue     = (state == A_STREAM) && !rd_idx[CW] && ((cnt < 2'd2) || pop);
    assign push_last = (rd_idx[CW-1:0] == {CW{1'b1}});
    assign rd_addr   = {layer_q, rd_idx[CW-1:0]};
    assign hit_new   = (bw_wr && bw_layer == new_layer) || (ba_wr && ba_layer == new_layer);
    assign hit_cur   = (bw_wr && bw_layer == layer_q) || (ba_wr && ba_layer == layer_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= A_IDLE;
            layer_q <= '0;
            rd_idx  <= '0;
            stale   <= 1'b0;
            a_err   <= 1'b0;
            cnt     <= 2'd0;
            q0      <= '0;
            q1      <= '0;
            q0_last <= 1'b0;
            q1_last <= 1'b0;
        end else begin
            a_err <= 1'b0;
            case (state)
                A_IDLE: begin
                    if (req_fire) begin
                        if (layer_ok) begin
                            layer_q <= new_layer;
                            rd_idx  <= '0;
                            stale   <= hit_new;
                            state   <= A_STREAM;
                        end else begin
                            a_err <= 1'b1;
                        end
                    end
                end
                A_STREAM: begin
                    if (!rd_idx[CW]) stale <= stale | hit_cur;
                    if (issue) rd_idx <= rd_idx + 1'b1;
                    if (pop && q0_last) state <= A_IDLE;
                end
                default: state <= A_IDLE;
            endcase

            case ({issue, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        q0      <= weight_mem[rd_addr];
                        q0_last <= push_last;
                    end else begin
                        q1      <= weight_mem[rd_addr];
                        q1_last <= push_last;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    q0      <= q1;
                    q0_last <= q1_last;
                    cnt     <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        q0      <= weight_mem[rd_addr];
                        q0_last <= push_last;
                    end else begin
                        q0      <= q1;
                        q0_last <= q1_last;
                        q1      <= weight_mem[rd_addr];
                        q1_last <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.init_done    = init_done;
    assign bus.weight_rdata = weight_rdata;
    assign bus.accum_rdata  = accum_rdata;
    assign bus.b_oob        = b_oob;
    assign bus.a_req_ready  = req_ready;
    assign bus.a_err        = a_err;
    assign bus.a_tvalid     = (cnt != 2'd0);
    assign bus.a_tdata      = q0;
    assign bus.a_tlast      = (cnt != 2'd0) && q0_last;
    assign bus.a_tuser      = (cnt != 2'd0) && q0_last && stale;
endmodule
